// File: rtl/simon2share_pkg.sv
// Shared types and constants for the two-share Simon 128/128 serial loader.
package simon2share_pkg;

  localparam int BLK_W  = 128;
  localparam int KEY_W  = 128;
  localparam int PISO_W = BLK_W + KEY_W;

  // Phase codes driven on data_rdy towards the core.
  localparam logic [1:0] RDY_IDLE = 2'b00;
  localparam logic [1:0] RDY_KEY  = 2'b10;
  localparam logic [1:0] RDY_PT   = 2'b01;
  localparam logic [1:0] RDY_RUN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_PT   = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/simon2share_piso.sv
// Single-share parallel-in serial-out register holding {pt, key}.
// The key sits in the low half so it leaves first, LSB first, followed by
// the plaintext. Zeros shift in from the top, so the tap reads 0 once the
// whole word has been sent.
module simon2share_piso
  import simon2share_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [PISO_W-1:0] din,
  output logic              tap
);

  logic [PISO_W-1:0] sreg;

  // Load has priority; otherwise shift right by one bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {1'b0, sreg[PISO_W-1:1]};
    end
  end

  assign tap = sreg[0];

endmodule

// File: rtl/simon2share_loader.sv
// Host-side serial driver for the two-share Simon 128/128 core.
// Handshake: start is a request sampled only in IDLE (a start while busy is
// dropped, never queued); the core sees a bit on data_ina/data_inb every
// cycle that data_rdy carries KEY or PT, and answers with a core_done level
// that is only honoured in RUN. ct_valid and err are single-cycle strobes.
// Shares A and B travel through separate registers and are never combined.
module simon2share_loader
  import simon2share_pkg::*;
#(
  parameter int RUN_TIMEOUT = 4096,
  parameter int CNT_W       = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_a,
  input  logic [KEY_W-1:0] key_b,
  input  logic [BLK_W-1:0] pt_a,
  input  logic [BLK_W-1:0] pt_b,
  output logic             data_ina,
  output logic             data_inb,
  output logic [1:0]       data_rdy,
  input  logic [BLK_W-1:0] cipher_in,
  input  logic             core_done,
  output logic [BLK_W-1:0] ct_out,
  output logic             ct_valid,
  output logic             busy,
  output logic             err,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_TIMEOUT - 1);

  state_t           state;
  logic [6:0]       bit_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic             piso_load;
  logic             piso_shift;

  assign piso_load  = (state == ST_IDLE) && start;
  assign piso_shift = (state == ST_KEY) || (state == ST_PT);
  assign dbg_state  = state;

  simon2share_piso u_piso_a (
    .clk   (clk),
    .rst   (rst),
    .load  (piso_load),
    .shift (piso_shift),
    .din   ({pt_a, key_a}),
    .tap   (data_ina)
  );

  simon2share_piso u_piso_b (
    .clk   (clk),
    .rst   (rst),
    .load  (piso_load),
    .shift (piso_shift),
    .din   ({pt_b, key_b}),
    .tap   (data_inb)
  );

  // Phase sequencing, bit/timeout counting and ciphertext capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      data_rdy <= RDY_IDLE;
      bit_cnt  <= '0;
      run_cnt  <= '0;
      ct_out   <= '0;
      ct_valid <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ct_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_KEY;
            data_rdy <= RDY_KEY;
            busy     <= 1'b1;
            bit_cnt  <= '0;
          end
        end
        ST_KEY: begin
          bit_cnt <= bit_cnt + 7'd1;
          if (bit_cnt == 7'd127) begin
            state    <= ST_PT;
            data_rdy <= RDY_PT;
          end
        end
        ST_PT: begin
          bit_cnt <= bit_cnt + 7'd1;
          if (bit_cnt == 7'd127) begin
            state    <= ST_RUN;
            data_rdy <= RDY_RUN;
            run_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (core_done) begin
            ct_out   <= cipher_in;
            ct_valid <= 1'b1;
            state    <= ST_IDLE;
            data_rdy <= RDY_IDLE;
            busy     <= 1'b0;
          end else if (run_cnt == RUN_LAST) begin
            err      <= 1'b1;
            state    <= ST_IDLE;
            data_rdy <= RDY_IDLE;
            busy     <= 1'b0;
          end else begin
            run_cnt <= run_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state    <= ST_IDLE;
          data_rdy <= RDY_IDLE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon2share_loader.sv
// Directed bench for simon2share_loader with a small stand-in core.
module tb_simon2share_loader;

  localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] KAT_PT  = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] KAT_CT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;
  localparam logic [127:0] K2      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P2      = 128'hdeadbeef0123456789abcdeffedcba98;

  // Clock/reset and DUT signals.
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_a = '0, key_b = '0, pt_a = '0, pt_b = '0;
  logic         data_ina, data_inb;
  logic [1:0]   data_rdy;
  logic [127:0] cipher_in = '0;
  logic         core_done = 1'b0;
  logic [127:0] ct_out;
  logic         ct_valid, busy, err;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  simon2share_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_a     (key_a),
    .key_b     (key_b),
    .pt_a      (pt_a),
    .pt_b      (pt_b),
    .data_ina  (data_ina),
    .data_inb  (data_inb),
    .data_rdy  (data_rdy),
    .cipher_in (cipher_in),
    .core_done (core_done),
    .ct_out    (ct_out),
    .ct_valid  (ct_valid),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Scoreboard state.
  logic [127:0] exp_q[$];
  logic [127:0] last_rk, last_rp;
  bit           hold_start = 1'b0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stand-in core: the known-answer pair maps to its published ciphertext,
  // anything else to a fixed scramble so a wrong load shows up in ct_out.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == KAT_KEY && p == KAT_PT) return KAT_CT;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_0000_ffff_1234_a5a5_c3c3_0f0f_9876;
  endfunction

  // Driver: request a load in the current (IDLE) cycle and collect the
  // 256-bit serial stream. abort_at >= 0 fires rst during that stream bit.
  task automatic load_op(input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] mk, input logic [127:0] mp,
                         input bit repulse, input int abort_at);
    logic [127:0] rk, rp;
    int bad_rdy, inb_ones;
    rk = '0; rp = '0; bad_rdy = 0; inb_ones = 0;
    key_a = k ^ mk; key_b = mk; pt_a = p ^ mp; pt_b = mp;
    start = 1'b1;
    exp_q.push_back(core_fn(k, p));
    @(negedge clk);
    start = hold_start;
    key_a = rand128(); key_b = rand128(); pt_a = rand128(); pt_b = rand128();
    for (int c = 0; c < 256; c++) begin
      if (data_rdy !== ((c < 128) ? 2'b10 : 2'b01)) bad_rdy++;
      if (c < 128) rk[c] = data_ina ^ data_inb;
      else rp[c-128] = data_ina ^ data_inb;
      if (data_inb) inb_ones++;
      if (c == abort_at) begin
        start = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async_rdy", 128'(data_rdy), 128'(0));
        check("rst_async_busy", 128'(busy), 128'(0));
        check("rst_async_ct", ct_out, 128'(0));
        check("rst_async_ins", 128'({data_ina, data_inb}), 128'(0));
        check("rst_async_state", 128'(dbg_state), 128'(0));
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      start = hold_start || (repulse && (c == 5 || c == 140));
      @(negedge clk);
    end
    last_rk = rk; last_rp = rp;
    check("load_phase_errs", 128'(bad_rdy), 128'(0));
    check("key_stream", rk, k);
    check("pt_stream", rp, p);
    if (mk == '0 && mp == '0) check("inb_zero", 128'(inb_ones), 128'(0));
    check("rdy_run", 128'(data_rdy), 128'(2'b11));
    check("busy_run", 128'(busy), 128'(1));
  endtask

  // Driver: answer from the stand-in core after 'latency' RUN cycles.
  task automatic run_op(input int latency, input bit repulse);
    int early, late;
    logic [127:0] e;
    early = 0; late = 0;
    cipher_in = core_fn(last_rk, last_rp);
    for (int i = 0; i < latency; i++) begin
      if (ct_valid || data_rdy !== 2'b11) early++;
      core_done = 1'b0;
      start = hold_start || (repulse && i == 2);
      @(negedge clk);
    end
    core_done = 1'b1;
    start = hold_start;
    @(negedge clk);
    core_done = 1'b0;
    e = exp_q.pop_front();
    check("run_hold", 128'(early), 128'(0));
    check("ct_valid", 128'(ct_valid), 128'(1));
    check("ct_out", ct_out, e);
    check("rdy_idle_done", 128'(data_rdy), 128'(0));
    check("busy_done", 128'(busy), 128'(0));
    if (!hold_start) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (ct_valid || busy) late++;
      end
      check("single_valid", 128'(late), 128'(0));
    end
  endtask

  // Driver: no core_done at all; err must fire RUN_TIMEOUT cycles in.
  task automatic run_timeout(input logic [127:0] prev_ct);
    int n;
    n = 0;
    void'(exp_q.pop_front());
    cipher_in = rand128();
    core_done = 1'b0;
    while (n < 5000 && err !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 128'(n), 128'(4096));
    check("timeout_ct_kept", ct_out, prev_ct);
    check("timeout_busy", 128'(busy), 128'(0));
    check("timeout_rdy", 128'(data_rdy), 128'(0));
    check("timeout_no_valid", 128'(ct_valid), 128'(0));
    @(negedge clk);
    check("err_one_cycle", 128'(err), 128'(0));
  endtask

  initial begin
    logic [127:0] m1, m2;
    int stray;
    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_rdy", 128'(data_rdy), 128'(0));
    check("rst_ct", ct_out, 128'(0));
    check("rst_flags", 128'({ct_valid, busy, err}), 128'(0));
    check("rst_ins", 128'({data_ina, data_inb}), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Known answer with a random mask.
    m1 = rand128(); m2 = rand128();
    load_op(KAT_KEY, KAT_PT, m1, m2, 1'b0, -1);
    run_op(5, 1'b0);

    // Zero mask.
    load_op(KAT_KEY, KAT_PT, '0, '0, 1'b0, -1);
    run_op(3, 1'b0);

    // start re-pulsed in KEY, PT and RUN.
    m1 = rand128(); m2 = rand128();
    load_op(KAT_KEY, KAT_PT, m1, m2, 1'b1, -1);
    run_op(7, 1'b1);

    // Core never finishes.
    load_op(K2, P2, rand128(), rand128(), 1'b0, -1);
    run_timeout(KAT_CT);

    // core_done outside RUN is ignored.
    stray = 0;
    core_done = 1'b1;
    cipher_in = rand128();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ct_valid || busy) stray++;
    end
    core_done = 1'b0;
    check("idle_done_ignored", 128'(stray), 128'(0));
    check("idle_ct_kept", ct_out, KAT_CT);

    // Reset at the 60th key bit, then a fresh complete operation.
    load_op(KAT_KEY, KAT_PT, rand128(), rand128(), 1'b0, 59);
    load_op(KAT_KEY, KAT_PT, rand128(), rand128(), 1'b0, -1);
    run_op(4, 1'b0);

    // Back-to-back with start held high.
    hold_start = 1'b1;
    load_op(KAT_KEY, KAT_PT, rand128(), rand128(), 1'b0, -1);
    run_op(2, 1'b0);
    load_op(K2, P2, rand128(), rand128(), 1'b0, -1);
    run_op(4, 1'b0);
    hold_start = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("b2b_idle_busy", 128'(busy), 128'(0));
    check("b2b_ct_held", ct_out, core_fn(K2, P2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/simon2share_loader.md
# simon2share_loader

Host-side serial driver for the two-share round-based Simon 128/128 core. It latches a 2-share key and plaintext in parallel, then streams them LSB-first on the core's serial load interface: data_ina/data_inb paired with data_rdy phase codes. It then holds the core in run mode until the core reports completion and returns the captured ciphertext with a one-cycle valid strobe. It sits between the bus/UART front end and the simon2share core.

## Interface
- RUN_TIMEOUT, 4096: maximum cycles in RUN before abort with err.
- CNT_W, 13: width of the RUN timeout counter; must hold RUN_TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- key_a, key_b  in  128 each  key shares; key = key_a ^ key_b.
- pt_a, pt_b  in  128 each  plaintext shares.
- data_ina, data_inb  out  1 each  serial share bits to core.
- data_rdy  out  2  phase code to core: 00 idle, 10 key, 01 plaintext, 11 run.
- cipher_in  in  128  core ciphertext.
- core_done  in  1  core completion (level).
- ct_out  out  128  captured ciphertext; held until next capture or reset.
- ct_valid  out  1  one-cycle strobe when ct_out updates.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle strobe on RUN timeout.

## Operation
- States: IDLE, KEY, PT, RUN.
- Reset values: state IDLE; data_rdy 00; data_ina, data_inb 0; ct_out 0; ct_valid 0; busy 0; err 0; counters 0.
- IDLE, start=1: latch all four share words into internal shift registers and enter KEY. Inputs may change freely afterwards.
- KEY: data_rdy=10 and data_ina/data_inb = key_a[i]/key_b[i] for i = 0..127, one bit per cycle, LSB first. After bit 127, enter PT.
- PT: data_rdy=01 and pt_a[i]/pt_b[i] for i = 0..127. After bit 127, enter RUN.
- RUN: data_rdy=11, held. On the first edge where core_done=1:
  - ct_out <= cipher_in.
  - ct_valid=1 for that cycle.
  - Return to IDLE with data_rdy=00.
- RUN timeout: if RUN_TIMEOUT cycles elapse without core_done, err=1 for one cycle, ct_out is unchanged, and the state returns to IDLE.
- Shares are never recombined. Share A and share B occupy separate registers and separate datapaths, and no logic XORs an a-bit with a b-bit.
- start while busy is ignored; it is not queued.
- core_done outside RUN is ignored.
- rst asserted mid-operation returns all outputs to their reset values immediately, asynchronously. The core must then be re-loaded from scratch.

## Timing
- All outputs are registered.
- start sampled at edge T0:
  - KEY bit 0 is presented in the cycle after T0.
  - Key bits occupy cycles T0+1..T0+128.
  - Plaintext bits occupy cycles T0+129..T0+256.
  - data_rdy=11 from T0+257.
- core_done seen at edge Tn in RUN: ct_valid and the new ct_out are visible in the cycle after Tn; data_rdy=00 in that same cycle.
- Minimum start-to-start spacing: 258 cycles plus core latency.
- A start asserted in the ct_valid cycle is accepted, because the state is IDLE then.
- Bit counter: 7 bits, wraps 127 -> 0 on each phase change.
- Timeout counter: CNT_W bits, cleared on RUN entry.

## Structure
- Shared package simon2share_pkg holds:
  - State enum.
  - Phase constants RDY_IDLE=2'b00, RDY_KEY=2'b10, RDY_PT=2'b01, RDY_RUN=2'b11.
  - BLK_W=128 and KEY_W=128.
- One sub-module, simon2share_piso: a single-share 256-bit parallel-in serial-out register with load, shift and bit-0 tap, holding {pt, key}.
  - Instantiated twice, once for share A and once for share B, so the shares stay physically separate.
- The top level holds the FSM, the counters and the ct_out capture register.

## Test plan
- Known-answer vector:
  - key = 0f0e0d0c0b0a09080706050403020100, pt = 63736564207372656c6c657661727420.
  - key_b/pt_b = any random mask, with a-shares = value ^ mask.
  - Checks:
    - Exactly 128 cycles of data_rdy=10 followed by 128 cycles of 01, then 11.
    - a^b of the serial bits reproduces the key and plaintext LSB-first.
    - With the core attached, ct_out = 49681b1e1e54fe3f65aa832af84e0bbc and ct_valid pulses once.
- Zero mask (b-shares = 0): same ct_out; data_inb stays 0 for all 256 load cycles.
- start re-pulsed during KEY, PT and RUN: no restart, the serial stream is unchanged, and exactly one ct_valid results.
- Stub core that never raises core_done: err pulses exactly RUN_TIMEOUT cycles after RUN entry; ct_out keeps its prior value; busy drops.
- rst asserted at the 60th KEY bit: all outputs return to reset values without waiting for a clock edge; a fresh start then produces a full, correct 256-bit stream.
- Back-to-back: start held high continuously produces a new load sequence beginning the cycle after each ct_valid, with the second ciphertext correct.
